// File: rtl/decim_pkg.sv
// Shared types for the receive DSP chain: packet FSM states and the AXIS beat
// carried between the FIR and decimator stages.
package decim_pkg;

  localparam int PKT_COUNT_WIDTH = 16;
  localparam int BEAT_DATA_WIDTH = 32;
  localparam int BEAT_STRB_WIDTH = BEAT_DATA_WIDTH / 8;

  typedef enum logic {
    IDLE,
    IN_PKT
  } state_t;

  typedef struct packed {
    logic [BEAT_DATA_WIDTH-1:0] tdata;
    logic [BEAT_STRB_WIDTH-1:0] tstrb;
    logic                       tlast;
  } beat_t;

endpackage

// File: rtl/axis_decimator_if.sv
// AXI-Stream bundle for the decimator; master drives the beat, slave drives tready.
interface axis_decimator_if #(
  parameter int DATA_WIDTH = 32
) ();

  logic                    tvalid;
  logic                    tready;
  logic                    tlast;
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tstrb;

  modport master (output tvalid, tlast, tdata, tstrb, input tready);
  modport slave  (input tvalid, tlast, tdata, tstrb, output tready);

endinterface

// File: rtl/axis_skid_buffer.sv
// Two-entry output skid buffer: entry 0 drives the output, entry 1 catches the
// beat that arrives while entry 0 is stalled, so upstream ready can be registered.
module axis_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_dn_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_up_ready
);

  logic             r_v0;
  logic             r_v1;
  logic [WIDTH-1:0] r_d0;
  logic [WIDTH-1:0] r_d1;
  logic             r_up_ready;
  logic             w_pop;
  logic             w_v0_nx;
  logic             w_v1_nx;
  logic [WIDTH-1:0] w_d0_nx;
  logic [WIDTH-1:0] w_d1_nx;

  assign w_pop = r_v0 && i_dn_ready;

  // Pushes only arrive while entry 1 is empty, because upstream ready tracks it.
  always_comb begin
    w_v0_nx = r_v0;
    w_v1_nx = r_v1;
    w_d0_nx = r_d0;
    w_d1_nx = r_d1;
    if (r_v1) begin
      if (w_pop) begin
        w_d0_nx = r_d1;
        w_v1_nx = 1'b0;
      end
    end else if (i_push) begin
      if (!r_v0 || w_pop) begin
        w_d0_nx = i_data;
        w_v0_nx = 1'b1;
      end else begin
        w_d1_nx = i_data;
        w_v1_nx = 1'b1;
      end
    end else if (w_pop) begin
      w_v0_nx = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v0       <= 1'b0;
      r_v1       <= 1'b0;
      r_d0       <= '0;
      r_d1       <= '0;
      r_up_ready <= 1'b0;
    end else begin
      r_v0       <= w_v0_nx;
      r_v1       <= w_v1_nx;
      r_d0       <= w_d0_nx;
      r_d1       <= w_d1_nx;
      r_up_ready <= !w_v1_nx;
    end
  end

  assign o_valid    = r_v0;
  assign o_data     = r_d0;
  assign o_up_ready = r_up_ready;

endmodule

// File: rtl/axis_decimator.sv
// Integer-ratio AXIS decimator: keeps one beat in R plus every packet-terminating
// beat, with the ratio latched per packet and a skid buffer on the output side.
module axis_decimator
  import decim_pkg::*;
#(
  parameter int C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int RATIO_WIDTH            = 8
) (
  input  logic                       s00_axis_aclk,
  input  logic                       s00_axis_aresetn,
  input  logic [RATIO_WIDTH-1:0]     decim_ratio,
  axis_decimator_if.slave            s00_axis,
  axis_decimator_if.master           m00_axis,
  output logic [PKT_COUNT_WIDTH-1:0] pkt_count
);

  localparam int BEAT_WIDTH = $bits(beat_t);

  state_t                     r_state;
  state_t                     w_state_nx;
  logic [RATIO_WIDTH-1:0]     r_lat;
  logic [RATIO_WIDTH-1:0]     r_ph;
  logic [RATIO_WIDTH-1:0]     w_ph;
  logic [RATIO_WIDTH-1:0]     w_ph_inc;
  logic [RATIO_WIDTH-1:0]     w_lat_m1;
  logic [RATIO_WIDTH-1:0]     w_ratio_in;
  logic [PKT_COUNT_WIDTH-1:0] r_pkt_count;
  logic                       w_accept;
  logic                       w_keep;
  logic                       w_s_ready;
  logic                       w_m_valid;
  logic                       w_out_hs;
  logic [BEAT_WIDTH-1:0]      w_out_bits;
  beat_t                      w_in_beat;
  beat_t                      w_out_beat;

  assign w_accept   = s00_axis.tvalid && w_s_ready;
  assign w_ratio_in = (decim_ratio == '0) ? RATIO_WIDTH'(1) : decim_ratio;
  assign w_lat_m1   = r_lat - RATIO_WIDTH'(1);
  assign w_ph_inc   = (r_ph >= w_lat_m1) ? '0 : r_ph + RATIO_WIDTH'(1);

  // Phase of the beat being offered now; packet starts always restart at zero.
  assign w_ph   = (r_state == IDLE) ? '0 : w_ph_inc;
  assign w_keep = w_accept && ((w_ph == '0) || s00_axis.tlast);

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    if (w_accept) begin
      w_state_nx = s00_axis.tlast ? IDLE : IN_PKT;
    end
  end

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      r_lat <= RATIO_WIDTH'(1);
      r_ph  <= '0;
    end else if (w_accept) begin
      r_ph <= w_ph;
      if (r_state == IDLE) begin
        r_lat <= w_ratio_in;
      end
    end
  end

  always_comb begin
    w_in_beat       = '0;
    w_in_beat.tdata = s00_axis.tdata[C_S00_AXIS_TDATA_WIDTH-1:0];
    w_in_beat.tstrb = s00_axis.tstrb;
    w_in_beat.tlast = s00_axis.tlast;
  end

  axis_skid_buffer #(
    .WIDTH (BEAT_WIDTH)
  ) u_skid (
    .clk        (s00_axis_aclk),
    .rst_n      (s00_axis_aresetn),
    .i_push     (w_keep),
    .i_data     (w_in_beat),
    .i_dn_ready (m00_axis.tready),
    .o_valid    (w_m_valid),
    .o_data     (w_out_bits),
    .o_up_ready (w_s_ready)
  );

  assign w_out_beat = beat_t'(w_out_bits);
  assign w_out_hs   = w_m_valid && m00_axis.tready;

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      r_pkt_count <= '0;
    end else if (w_out_hs && w_out_beat.tlast) begin
      r_pkt_count <= r_pkt_count + PKT_COUNT_WIDTH'(1);
    end
  end

  assign s00_axis.tready = w_s_ready;
  assign m00_axis.tvalid = w_m_valid;
  assign m00_axis.tdata  = w_out_beat.tdata[C_M00_AXIS_TDATA_WIDTH-1:0];
  assign m00_axis.tstrb  = w_out_beat.tstrb;
  assign m00_axis.tlast  = w_out_beat.tlast;
  assign pkt_count       = r_pkt_count;

endmodule

// File: tb/tb_axis_decimator.sv
// Directed bench for axis_decimator: hand-computed kept-beat lists per scenario,
// checked against a negedge monitor of output handshakes.
module tb_axis_decimator;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic [7:0]  ratio = 8'd1;
  logic [15:0] pktCount;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int expPkt = 0;

  logic [36:0] expQ[$];
  logic [36:0] outQ[$];
  int          inCyc[$];
  int          outCyc[$];

  axis_decimator_if #(.DATA_WIDTH(32)) sIf ();
  axis_decimator_if #(.DATA_WIDTH(32)) mIf ();

  axis_decimator #(
    .C_S00_AXIS_TDATA_WIDTH (32),
    .C_M00_AXIS_TDATA_WIDTH (32),
    .RATIO_WIDTH            (8)
  ) dut (
    .s00_axis_aclk    (clk),
    .s00_axis_aresetn (rstN),
    .decim_ratio      (ratio),
    .s00_axis         (sIf),
    .m00_axis         (mIf),
    .pkt_count        (pktCount)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rstN && mIf.tvalid && mIf.tready) begin
      outQ.push_back({mIf.tlast, mIf.tstrb, mIf.tdata});
      outCyc.push_back(cyc);
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // Offers one beat and holds it until accepted; strobes are derived from the data.
  task automatic applyStimulus(input logic [31:0] d, input logic l);
    int waitCnt;
    waitCnt = 0;
    sIf.tvalid = 1'b1;
    sIf.tdata  = d;
    sIf.tstrb  = d[3:0];
    sIf.tlast  = l;
    @(negedge clk);
    while (!sIf.tready && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!sIf.tready) checkOutput("accept_timeout", 64'(waitCnt), 64'(0));
    inCyc.push_back(cyc);
    @(posedge clk);
    #1;
  endtask

  task automatic expBeat(input logic [31:0] d, input logic l);
    expQ.push_back({l, d[3:0], d});
  endtask

  task automatic clearQueues();
    expQ.delete();
    outQ.delete();
    inCyc.delete();
    outCyc.delete();
  endtask

  task automatic finishPacket();
    sIf.tvalid = 1'b0;
    sIf.tlast  = 1'b0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic compareQueues(input string tag);
    int n;
    checkOutput({tag, "_count"}, 64'(outQ.size()), 64'(expQ.size()));
    n = (outQ.size() < expQ.size()) ? outQ.size() : expQ.size();
    for (int i = 0; i < n; i++)
      checkOutput($sformatf("%s_beat%0d", tag, i), 64'(outQ[i]), 64'(expQ[i]));
  endtask

  task automatic checkStreaming(input string tag);
    int n;
    n = (outCyc.size() < inCyc.size()) ? outCyc.size() : inCyc.size();
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s_lat%0d", tag, i), 64'(outCyc[i] - inCyc[i]), 64'(1));
      checkOutput($sformatf("%s_rate%0d", tag, i), 64'(outCyc[i] - outCyc[0]), 64'(i));
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_s_tready"}, 64'(sIf.tready), 64'(0));
    checkOutput({tag, "_m_tvalid"}, 64'(mIf.tvalid), 64'(0));
    checkOutput({tag, "_m_tlast"}, 64'(mIf.tlast), 64'(0));
    checkOutput({tag, "_m_tdata"}, 64'(mIf.tdata), 64'(0));
    checkOutput({tag, "_m_tstrb"}, 64'(mIf.tstrb), 64'(0));
    checkOutput({tag, "_pkt_count"}, 64'(pktCount), 64'(0));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    sIf.tvalid = 1'b0;
    sIf.tlast  = 1'b0;
    sIf.tdata  = '0;
    sIf.tstrb  = '0;
    mIf.tready = 1'b1;

    #2;
    checkAllZero("reset");
    @(posedge clk);
    #1 rstN = 1'b1;
    @(negedge clk);
    checkOutput("tready_before_edge", 64'(sIf.tready), 64'(0));
    @(negedge clk);
    checkOutput("tready_after_edge", 64'(sIf.tready), 64'(1));
    @(posedge clk);
    #1;

    // Ratio 4 over a 16-beat packet
    ratio = 8'd4;
    clearQueues();
    for (int i = 0; i < 16; i++) applyStimulus(32'(i), i == 15);
    finishPacket();
    expBeat(0, 0); expBeat(4, 0); expBeat(8, 0); expBeat(12, 0); expBeat(15, 1);
    compareQueues("r4");
    expPkt = 1;
    checkOutput("r4_pkt_count", 64'(pktCount), 64'(expPkt));

    // Ratio 0 behaves as ratio 1
    ratio = 8'd0;
    clearQueues();
    for (int i = 0; i < 8; i++) applyStimulus(32'(100 + i), i == 7);
    finishPacket();
    for (int i = 0; i < 8; i++) expBeat(32'(100 + i), i == 7);
    compareQueues("r0");
    checkStreaming("r0");
    expPkt = 2;
    checkOutput("r0_pkt_count", 64'(pktCount), 64'(expPkt));

    ratio = 8'd1;
    clearQueues();
    for (int i = 0; i < 8; i++) applyStimulus(32'(200 + i), i == 7);
    finishPacket();
    for (int i = 0; i < 8; i++) expBeat(32'(200 + i), i == 7);
    compareQueues("r1");
    checkStreaming("r1");
    expPkt = 3;
    checkOutput("r1_pkt_count", 64'(pktCount), 64'(expPkt));

    // Ratio changes mid-packet only take effect on the next packet
    ratio = 8'd3;
    clearQueues();
    for (int i = 0; i < 10; i++) begin
      if (i == 2) ratio = 8'd5;
      applyStimulus(32'(i), i == 9);
    end
    for (int i = 0; i < 10; i++) applyStimulus(32'(i), i == 9);
    finishPacket();
    expBeat(0, 0); expBeat(3, 0); expBeat(6, 0); expBeat(9, 1);
    expBeat(0, 0); expBeat(5, 0); expBeat(9, 1);
    compareQueues("chg");
    expPkt = 5;
    checkOutput("chg_pkt_count", 64'(pktCount), 64'(expPkt));

    // Downstream stall of five cycles while streaming at ratio 1
    ratio = 8'd1;
    clearQueues();
    fork
      begin
        for (int i = 0; i < 12; i++) applyStimulus(32'h300 + 32'(i), i == 11);
      end
      begin
        repeat (4) @(posedge clk);
        #1 mIf.tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          checkOutput($sformatf("bp_s_tready%0d", i), 64'(sIf.tready), 64'(i == 0));
          checkOutput($sformatf("bp_m_tvalid%0d", i), 64'(mIf.tvalid), 64'(1));
          checkOutput($sformatf("bp_m_tdata%0d", i), 64'(mIf.tdata), 64'(32'h300 + 32'(outQ.size())));
        end
        @(posedge clk);
        #1 mIf.tready = 1'b1;
        @(negedge clk);
        checkOutput("bp_s_tready_drain", 64'(sIf.tready), 64'(0));
        @(negedge clk);
        checkOutput("bp_s_tready_back", 64'(sIf.tready), 64'(1));
      end
    join
    finishPacket();
    for (int i = 0; i < 12; i++) expBeat(32'h300 + 32'(i), i == 11);
    compareQueues("bp");
    expPkt = 6;
    checkOutput("bp_pkt_count", 64'(pktCount), 64'(expPkt));

    // Back-to-back single-beat packets
    ratio = 8'd7;
    clearQueues();
    applyStimulus(32'hA, 1'b1);
    applyStimulus(32'hB, 1'b1);
    applyStimulus(32'hC, 1'b1);
    finishPacket();
    expBeat(32'hA, 1); expBeat(32'hB, 1); expBeat(32'hC, 1);
    compareQueues("single");
    expPkt = 9;
    checkOutput("single_pkt_count", 64'(pktCount), 64'(expPkt));

    // Asynchronous reset in the middle of a packet
    ratio = 8'd2;
    clearQueues();
    for (int i = 0; i < 6; i++) applyStimulus(32'h500 + 32'(i), 1'b0);
    sIf.tvalid = 1'b0;
    #2 rstN = 1'b0;
    #1;
    checkAllZero("async_rst");
    @(posedge clk);
    #1 rstN = 1'b1;
    @(posedge clk);
    #1;
    clearQueues();
    for (int i = 0; i < 4; i++) applyStimulus(32'h600 + 32'(i), i == 3);
    finishPacket();
    expBeat(32'h600, 0); expBeat(32'h602, 0); expBeat(32'h603, 1);
    compareQueues("post_rst");
    expPkt = 1;
    checkOutput("post_rst_pkt_count", 64'(pktCount), 64'(expPkt));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
